// File: rtl/step_control_if.sv
// Step-counter / instruction-source / datapath bundle for step_control.
// master drives step, run and din; slave is the control unit.
interface step_control_if #(
  parameter int L_COUNT = 3,
  parameter int IR_W    = 9
);
  logic [L_COUNT-1:0] step;
  logic               run;
  logic [IR_W-1:0]    din;
  logic               step_clr;
  logic               ir_in;
  logic [7:0]         r_in;
  logic [7:0]         r_out;
  logic               a_in;
  logic               g_in;
  logic               g_out;
  logic               din_out;
  logic [1:0]         alu_op;
  logic               done;
  logic               illegal;
  logic               step_err;

  modport master (
    output step, run, din,
    input  step_clr, ir_in, r_in, r_out, a_in, g_in,
    input  g_out, din_out, alu_op, done, illegal, step_err
  );

  modport slave (
    input  step, run, din,
    output step_clr, ir_in, r_in, r_out, a_in, g_in,
    output g_out, din_out, alu_op, done, illegal, step_err
  );
endinterface

// File: rtl/step_control.sv
// Multi-cycle processor control unit: IR latch, step decode, DONE/STEP_CLR.
// Optional step-sequence checker enabled by macro STEP_CHECK_EN.
module step_control #(
  parameter int L_COUNT  = 3,
  parameter int IR_W     = 9,
  parameter int MUL_LAST = 6
) (
  input logic          CLK,
  input logic          CLR_N,
  step_control_if.slave bus
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [L_COUNT-1:0] T0  = '0;
  localparam logic [L_COUNT-1:0] T1  = L_COUNT'(1);
  localparam logic [L_COUNT-1:0] T2  = L_COUNT'(2);
  localparam logic [L_COUNT-1:0] T3  = L_COUNT'(3);
  localparam logic [L_COUNT-1:0] TML = L_COUNT'(MUL_LAST);

  state_e          state_q, state_d;
  logic [IR_W-1:0] ir_q, ir_d;
  logic [2:0]      op, rx, ry;
  logic            fin, abrt;

  assign op = ir_q[IR_W-1 -: 3];
  assign rx = ir_q[5:3];
  assign ry = ir_q[2:0];

  function automatic logic [7:0] oh(input logic [2:0] r);
    return 8'b1 << r;
  endfunction

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    fin          = 1'b0;
    abrt         = 1'b0;
    bus.step_clr = 1'b0;
    bus.ir_in    = 1'b0;
    bus.r_in     = '0;
    bus.r_out    = '0;
    bus.a_in     = 1'b0;
    bus.g_in     = 1'b0;
    bus.g_out    = 1'b0;
    bus.din_out  = 1'b0;
    bus.alu_op   = 2'b00;
    bus.illegal  = 1'b0;
    bus.done     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.step == T0 && bus.run) begin
          bus.ir_in = 1'b1;
          ir_d      = bus.din;
          state_d   = S_BUSY;
        end else begin
          bus.step_clr = 1'b1;
        end
      end
      S_BUSY: begin
        unique case (op)
          3'b000: begin
            if (bus.step == T1) begin
              bus.r_out = oh(ry);
              bus.r_in  = oh(rx);
              fin       = 1'b1;
            end else abrt = 1'b1;
          end
          3'b001: begin
            if (bus.step == T1) begin
              bus.din_out = 1'b1;
              bus.r_in    = oh(rx);
              fin         = 1'b1;
            end else abrt = 1'b1;
          end
          3'b010, 3'b011: begin
            if (bus.step == T1) begin
              bus.r_out = oh(rx);
              bus.a_in  = 1'b1;
            end else if (bus.step == T2) begin
              bus.r_out  = oh(ry);
              bus.g_in   = 1'b1;
              bus.alu_op = {1'b0, op[0]};
            end else if (bus.step == T3) begin
              bus.g_out = 1'b1;
              bus.r_in  = oh(rx);
              fin       = 1'b1;
            end else abrt = 1'b1;
          end
          3'b100: begin
            if (bus.step == T1) begin
              bus.r_out = oh(rx);
              bus.a_in  = 1'b1;
            end else if (bus.step == T2) begin
              bus.r_out  = oh(ry);
              bus.g_in   = 1'b1;
              bus.alu_op = 2'b10;
            end else if (bus.step >= T3 && bus.step < TML) begin
              bus.alu_op = 2'b10;
            end else if (bus.step == TML) begin
              bus.g_out = 1'b1;
              bus.r_in  = oh(rx);
              fin       = 1'b1;
            end else abrt = 1'b1;
          end
          default: begin
            if (bus.step == T1) begin
              bus.illegal = 1'b1;
              fin         = 1'b1;
            end else abrt = 1'b1;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
    if (fin) begin
      bus.done     = 1'b1;
      bus.step_clr = 1'b1;
      state_d      = S_IDLE;
    end
    // Out-of-range step while busy: drop the instruction and resync.
    if (abrt) begin
      bus.step_clr = 1'b1;
      state_d      = S_IDLE;
    end
  end

`ifdef STEP_CHECK_EN
  logic               prev_clr_q, chk_q, err_q;
  logic [L_COUNT-1:0] prev_step_q, exp_step;

  assign exp_step = prev_clr_q ? '0 : prev_step_q + L_COUNT'(1);

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      prev_clr_q  <= 1'b1;
      prev_step_q <= '0;
      chk_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_clr_q  <= bus.step_clr;
      prev_step_q <= bus.step;
      chk_q       <= 1'b1;
      if (chk_q && bus.step != exp_step) err_q <= 1'b1;
    end
  end

  assign bus.step_err = err_q;
`else
  assign bus.step_err = 1'b0;
`endif

endmodule

// File: tb/tb_step_control.sv
// Directed vector bench for step_control: table of cycles plus
// hand sequences for mult, abort-by-reset and the step checker.
module tb_step_control;

  logic CLK   = 1'b0;
  logic CLR_N = 1'b0;
  always #5 CLK = ~CLK;

  step_control_if #(.L_COUNT(3), .IR_W(9)) bus ();

  step_control #(.L_COUNT(3), .IR_W(9), .MUL_LAST(6)) dut (
    .CLK  (CLK),
    .CLR_N(CLR_N),
    .bus  (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        run;
    logic [8:0]  din;
    logic [2:0]  step;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[22];

  logic [25:0] outs;
  assign outs = {bus.step_clr, bus.ir_in, bus.r_in, bus.r_out,
                 bus.a_in, bus.g_in, bus.g_out, bus.din_out,
                 bus.alu_op, bus.done, bus.illegal};

  function automatic logic [25:0] ev(
    input logic clr, input logic irin,
    input logic [7:0] rin, input logic [7:0] rout,
    input logic ain, input logic gin, input logic gout,
    input logic dout, input logic [1:0] alu,
    input logic done, input logic ill);
    return {clr, irin, rin, rout, ain, gin, gout, dout, alu, done, ill};
  endfunction

  task automatic chk(input string nm, input logic [25:0] act,
                     input logic [25:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chk_err(input string nm, input logic exp);
    checks++;
    if (bus.step_err !== exp) begin
      failures++;
      $display("FAIL %s step_err got=%b expected=%b", nm, bus.step_err, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [8:0] d,
                       input logic [2:0] s);
    bus.run  = r;
    bus.din  = d;
    bus.step = s;
  endtask

  task automatic cyc(input string nm, input logic r, input logic [8:0] d,
                     input logic [2:0] s, input logic [25:0] exp);
    drive(r, d, s);
    @(negedge CLK);
    chk(nm, outs, exp);
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    CLR_N = 1'b0;
    drive(1'b0, 9'h0, 3'd0);
    @(posedge CLK);
    #1;
    CLR_N = 1'b1;
  endtask

  logic [25:0] C, IRN, e;

  initial begin
    C   = ev(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);
    IRN = ev(0, 1, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 0, 0);

    tbl[0]  = '{1'b0, 9'h000, 3'd0, C};
    tbl[1]  = '{1'b1, 9'b001_010_000, 3'd0, IRN};
    tbl[2]  = '{1'b0, 9'h1AB, 3'd1,
                ev(1, 0, 8'h04, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0)};
    tbl[3]  = '{1'b0, 9'h000, 3'd0, C};
    tbl[4]  = '{1'b1, 9'b010_001_010, 3'd0, IRN};
    tbl[5]  = '{1'b0, 9'h000, 3'd1,
                ev(0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 2'b00, 0, 0)};
    tbl[6]  = '{1'b0, 9'h000, 3'd2,
                ev(0, 0, 8'h00, 8'h04, 0, 1, 0, 0, 2'b00, 0, 0)};
    tbl[7]  = '{1'b0, 9'h000, 3'd3,
                ev(1, 0, 8'h02, 8'h00, 0, 0, 1, 0, 2'b00, 1, 0)};
    tbl[8]  = '{1'b1, 9'b110_000_000, 3'd0, IRN};
    tbl[9]  = '{1'b1, 9'b001_001_000, 3'd1,
                ev(1, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b00, 1, 1)};
    tbl[10] = '{1'b1, 9'b000_101_101, 3'd0, IRN};
    tbl[11] = '{1'b0, 9'h000, 3'd1,
                ev(1, 0, 8'h20, 8'h20, 0, 0, 0, 0, 2'b00, 1, 0)};
    tbl[12] = '{1'b1, 9'b011_111_000, 3'd0, IRN};
    tbl[13] = '{1'b0, 9'h000, 3'd1,
                ev(0, 0, 8'h00, 8'h80, 1, 0, 0, 0, 2'b00, 0, 0)};
    tbl[14] = '{1'b0, 9'h000, 3'd2,
                ev(0, 0, 8'h00, 8'h01, 0, 1, 0, 0, 2'b01, 0, 0)};
    tbl[15] = '{1'b0, 9'h000, 3'd3,
                ev(1, 0, 8'h80, 8'h00, 0, 0, 1, 0, 2'b00, 1, 0)};
    tbl[16] = '{1'b0, 9'h000, 3'd5, C};
    tbl[17] = '{1'b0, 9'h000, 3'd0, C};
    tbl[18] = '{1'b1, 9'b000_001_000, 3'd0, IRN};
    tbl[19] = '{1'b0, 9'h000, 3'd2, C};
    tbl[20] = '{1'b1, 9'b001_011_000, 3'd0, IRN};
    tbl[21] = '{1'b0, 9'h0FF, 3'd1,
                ev(1, 0, 8'h08, 8'h00, 0, 0, 0, 1, 2'b00, 1, 0)};

    drive(1'b0, 9'h0, 3'd0);
    do_reset();
    chk_err("reset_err", 1'b0);
    for (int i = 0; i < 22; i++)
      cyc($sformatf("vec%0d", i), tbl[i].run, tbl[i].din,
          tbl[i].step, tbl[i].exp);

    // mult r3,r0 across the full counter sequence; RUN held high is ignored
    do_reset();
    cyc("mul_t0", 1'b1, 9'b100_011_000, 3'd0, IRN);
    for (int s = 1; s <= 6; s++) begin
      if (s == 1)      e = ev(0, 0, 8'h00, 8'h08, 1, 0, 0, 0, 2'b00, 0, 0);
      else if (s == 2) e = ev(0, 0, 8'h00, 8'h01, 0, 1, 0, 0, 2'b10, 0, 0);
      else if (s < 6)  e = ev(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 0, 0);
      else             e = ev(1, 0, 8'h08, 8'h00, 0, 0, 1, 0, 2'b00, 1, 0);
      cyc($sformatf("mul_t%0d", s), 1'b1, 9'h000, 3'(s), e);
    end
    cyc("mul_idle", 1'b0, 9'h000, 3'd0, C);
    chk_err("mul_noerr", 1'b0);

    // reset in the middle of an add: no DONE, back to idle
    do_reset();
    cyc("rst_t0", 1'b1, 9'b010_001_010, 3'd0, IRN);
    cyc("rst_t1", 1'b0, 9'h000, 3'd1,
        ev(0, 0, 8'h00, 8'h02, 1, 0, 0, 0, 2'b00, 0, 0));
    CLR_N = 1'b0;
    drive(1'b0, 9'h000, 3'd2);
    @(posedge CLK);
    #1;
    CLR_N = 1'b1;
    cyc("rst_resync", 1'b0, 9'h000, 3'd3, C);
    cyc("rst_idle", 1'b0, 9'h000, 3'd0, C);

    // step sequence 0,1,3 without a clear
    do_reset();
    chk_err("chk_reset", 1'b0);
    cyc("chk_t0", 1'b1, 9'b100_011_000, 3'd0, IRN);
    cyc("chk_t1", 1'b0, 9'h000, 3'd1,
        ev(0, 0, 8'h00, 8'h08, 1, 0, 0, 0, 2'b00, 0, 0));
    chk_err("chk_seq_ok", 1'b0);
    cyc("chk_t3", 1'b0, 9'h000, 3'd3,
        ev(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 0, 0));
`ifdef STEP_CHECK_EN
    chk_err("chk_skip", 1'b1);
`else
    chk_err("chk_skip", 1'b0);
`endif
    cyc("chk_t4", 1'b0, 9'h000, 3'd4,
        ev(0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 2'b10, 0, 0));
`ifdef STEP_CHECK_EN
    chk_err("chk_sticky", 1'b1);
`else
    chk_err("chk_sticky", 1'b0);
`endif
    do_reset();
    chk_err("chk_cleared", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
